// File: rtl/lf_pkg.sv
// Shared types and constants for the line-follower controller.
package lf_pkg;

    // Controller states; encoding is visible on state_o
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_CORR_L = 3'd2,
        ST_CORR_R = 3'd3,
        ST_NODE   = 3'd4,
        ST_EXIT   = 3'd5,
        ST_TURN   = 3'd6,
        ST_LOST   = 3'd7
    } lf_state_e;

    // Turn command encodings from the path planner
    localparam logic [1:0] CMD_STRAIGHT = 2'd0;
    localparam logic [1:0] CMD_LEFT     = 2'd1;
    localparam logic [1:0] CMD_RIGHT    = 2'd2;
    localparam logic [1:0] CMD_STOP     = 2'd3;

    // Sensor word layout
    localparam int unsigned SNS_W = 3;
    localparam int unsigned SNS_L = 0;
    localparam int unsigned SNS_C = 1;
    localparam int unsigned SNS_R = 2;

    // Tracking decision for a word that is neither 000 nor 111:
    // symmetric words (010, 101) go straight, otherwise steer toward the lit side.
    function automatic lf_state_e track_state(input logic [SNS_W-1:0] f);
        lf_state_e st;
        if (f[SNS_L] == f[SNS_R]) begin
            st = ST_FOLLOW;
        end else if (f[SNS_L]) begin
            st = ST_CORR_L;
        end else begin
            st = ST_CORR_R;
        end
        return st;
    endfunction

endpackage

// File: rtl/motor_pwm.sv
// Dual-wheel PWM generator: one shared counter, two comparators.
// Duty values are sampled only at counter wrap so a period is never split.
module motor_pwm #(
    parameter int unsigned PWM_PERIOD = 2500,
    parameter int unsigned DUTY_W     = 12
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty_l,
    input  logic [DUTY_W-1:0] duty_r,
    output logic              pwm_l,
    output logic              pwm_r
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] act_l;
    logic [DUTY_W-1:0] act_r;
    logic              wrap;

    assign wrap = (cnt == CNT_LAST);

    // Free-running period counter, wrap-synchronous duty load, registered compare
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            cnt   <= '0;
            act_l <= '0;
            act_r <= '0;
            pwm_l <= 1'b0;
            pwm_r <= 1'b0;
        end else begin
            cnt   <= wrap ? '0 : cnt + DUTY_W'(1);
            if (wrap) begin
                act_l <= duty_l;
                act_r <= duty_r;
            end
            pwm_l <= (cnt < act_l);
            pwm_r <= (cnt < act_r);
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following AGV controller: sensor filter, tracking FSM, node counting,
// planner handshake and motor drive.
// Optional: define LF_LOST_RECOVERY_EN to make LOST spin back toward the line.
module line_follow_ctrl
    import lf_pkg::*;
#(
    parameter int unsigned FILT_CYCLES  = 50000,
    parameter int unsigned PWM_PERIOD   = 2500,
    parameter int unsigned DUTY_FAST    = 2000,
    parameter int unsigned DUTY_SLOW    = 800,
    parameter int unsigned TURN_MIN     = 500000,
    parameter int unsigned LOST_TIMEOUT = 2500000
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic [SNS_W-1:0] line_ls,
    input  logic             run_en,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_dir,
    output logic             cmd_ready,
    output logic             node_pulse,
    output logic [7:0]       node_count,
    output logic             pwm_l,
    output logic             pwm_r,
    output logic             dir_l,
    output logic             dir_r,
    output logic [2:0]       state_o
);

    localparam int unsigned FC_W    = $clog2(FILT_CYCLES + 1);
    localparam int unsigned DUTY_W  = $clog2(PWM_PERIOD + 1);
    localparam int unsigned TMR_MAX = (LOST_TIMEOUT > TURN_MIN) ? LOST_TIMEOUT : TURN_MIN;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [FC_W-1:0]   FILT_LAST = FC_W'(FILT_CYCLES - 1);
    localparam logic [DUTY_W-1:0] D_FAST    = DUTY_W'(DUTY_FAST);
    localparam logic [DUTY_W-1:0] D_SLOW    = DUTY_W'(DUTY_SLOW);
    localparam logic [TMR_W-1:0]  LOST_LIM  = TMR_W'(LOST_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TURN_LIM  = TMR_W'(TURN_MIN);

    localparam logic [SNS_W-1:0] W_NONE = 3'b000;
    localparam logic [SNS_W-1:0] W_ALL  = 3'b111;

    logic [SNS_W-1:0]  raw_q;
    logic [SNS_W-1:0]  filt;
    logic [FC_W-1:0]   filt_cnt;

    lf_state_e         state;
    lf_state_e         state_n;
    logic [TMR_W-1:0]  tmr;
    logic              turn_left;
    logic              turn_left_n;
    logic              tracking;
    logic [DUTY_W-1:0] duty_l;
    logic [DUTY_W-1:0] duty_r;
`ifdef LF_LOST_RECOVERY_EN
    logic              last_left;
`endif

    // Debounce: filtered word follows the raw word only after it has been stable
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            raw_q    <= '0;
            filt     <= '0;
            filt_cnt <= '0;
        end else begin
            raw_q <= line_ls;
            if (line_ls != raw_q) begin
                filt_cnt <= '0;
            end else if (filt_cnt != FILT_LAST) begin
                filt_cnt <= filt_cnt + FC_W'(1);
            end
            if (filt_cnt == FILT_LAST) begin
                filt <= raw_q;
            end
        end
    end

    // Next-state decode; run_en low overrides everything
    function automatic lf_state_e fsm_next(
        input lf_state_e        st,
        input logic [SNS_W-1:0] f,
        input logic [TMR_W-1:0] t,
        input logic             run,
        input logic             cv,
        input logic [1:0]       cd
    );
        lf_state_e nx;
        nx = st;
        if (!run) begin
            nx = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: nx = ST_FOLLOW;
                ST_FOLLOW, ST_CORR_L, ST_CORR_R: begin
                    if (f == W_ALL) begin
                        nx = ST_NODE;
                    end else if (f == W_NONE) begin
                        if (t >= LOST_LIM) begin
                            nx = ST_LOST;
                        end
                    end else begin
                        nx = track_state(f);
                    end
                end
                ST_NODE: begin
                    if (cv) begin
                        case (cd)
                            CMD_STRAIGHT:        nx = ST_EXIT;
                            CMD_LEFT, CMD_RIGHT: nx = ST_TURN;
                            CMD_STOP:            nx = ST_IDLE;
                            default:             nx = ST_IDLE;
                        endcase
                    end
                end
                // Stay until the junction has fully passed so it is counted once
                ST_EXIT: if (f != W_ALL) nx = ST_FOLLOW;
                ST_TURN: if ((t >= TURN_LIM) && f[SNS_C]) nx = ST_FOLLOW;
`ifdef LF_LOST_RECOVERY_EN
                ST_LOST: if (f != W_NONE) nx = ST_FOLLOW;
`else
                ST_LOST: nx = ST_LOST;
`endif
                default: nx = ST_IDLE;
            endcase
        end
        return nx;
    endfunction

    assign state_n     = fsm_next(state, filt, tmr, run_en, cmd_valid, cmd_dir);
    assign turn_left_n = (state == ST_NODE) ? (cmd_dir == CMD_LEFT) : turn_left;
    assign tracking    = (state == ST_FOLLOW) || (state == ST_CORR_L) || (state == ST_CORR_R);
    assign state_o     = state;

    // FSM state, timers, node counter and registered motor commands
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            turn_left  <= 1'b0;
            node_count <= '0;
            node_pulse <= 1'b0;
            cmd_ready  <= 1'b0;
            duty_l     <= '0;
            duty_r     <= '0;
            dir_l      <= 1'b1;
            dir_r      <= 1'b1;
`ifdef LF_LOST_RECOVERY_EN
            last_left  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            turn_left <= turn_left_n;
`ifdef LF_LOST_RECOVERY_EN
            if (filt != W_NONE) begin
                last_left <= filt[SNS_L];
            end
`endif
            // Shared timer: lost time while tracking, elapsed time while turning
            if (state_n != state) begin
                tmr <= '0;
            end else if ((state == ST_TURN) || (tracking && (filt == W_NONE))) begin
                if (tmr != '1) begin
                    tmr <= tmr + TMR_W'(1);
                end
            end else begin
                tmr <= '0;
            end

            node_pulse <= (state_n == ST_NODE) && (state != ST_NODE);
            if ((state_n == ST_NODE) && (state != ST_NODE)) begin
                node_count <= node_count + 8'd1;
            end
            cmd_ready <= (state_n == ST_NODE);

            duty_l <= '0;
            duty_r <= '0;
            dir_l  <= 1'b1;
            dir_r  <= 1'b1;
            case (state_n)
                ST_FOLLOW, ST_EXIT: begin
                    duty_l <= D_FAST;
                    duty_r <= D_FAST;
                end
                ST_CORR_L: begin
                    duty_l <= D_SLOW;
                    duty_r <= D_FAST;
                end
                ST_CORR_R: begin
                    duty_l <= D_FAST;
                    duty_r <= D_SLOW;
                end
                ST_TURN: begin
                    duty_l <= D_FAST;
                    duty_r <= D_FAST;
                    dir_l  <= ~turn_left_n;
                    dir_r  <= turn_left_n;
                end
`ifdef LF_LOST_RECOVERY_EN
                ST_LOST: begin
                    duty_l <= D_SLOW;
                    duty_r <= D_SLOW;
                    dir_l  <= ~last_left;
                    dir_r  <= last_left;
                end
`endif
                default: ;
            endcase
        end
    end

    motor_pwm #(
        .PWM_PERIOD(PWM_PERIOD),
        .DUTY_W    (DUTY_W)
    ) u_pwm (
        .clk_50(clk_50),
        .rst_n (rst_n),
        .duty_l(duty_l),
        .duty_r(duty_r),
        .pwm_l (pwm_l),
        .pwm_r (pwm_r)
    );

endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
- Downstream consumer of the 3-bit line-sensor word from the ADC front end (bit0 left, bit1 centre, bit2 right; 1 = black line).
- Filters the sensor word and runs the line-following state machine.
- Detects junctions (nodes), counts them, and hands off to the path planner through a valid/ready turn command.
- Drives left and right motor PWM and direction pins of the AGV.

Parameters:
- FILT_CYCLES, 50000: consecutive identical raw samples required before the filtered word updates (1 ms at 50 MHz).
- PWM_PERIOD, 2500: PWM counter period in clk_50 cycles (20 kHz).
- DUTY_FAST, 2000: compare value for the outer or straight wheel.
- DUTY_SLOW, 800: compare value for the inner wheel during correction.
- TURN_MIN, 500000: minimum cycles spent in TURN before the centre sensor is honoured.
- LOST_TIMEOUT, 2500000: cycles of filtered 000 before entering LOST.

Ports:
- clk_50  in  1  50 MHz system clock
- rst_n  in  1  synchronous active-low reset
- line_ls  in  3  raw line-sensor word from ADC stage
- run_en  in  1  1 = motion allowed; 0 = go to IDLE
- cmd_valid  in  1  turn command valid
- cmd_dir  in  2  0 straight, 1 left, 2 right, 3 stop
- cmd_ready  out  1  high only in NODE state
- node_pulse  out  1  one-cycle pulse on node entry
- node_count  out  8  nodes passed since reset
- pwm_l, pwm_r  out  1  motor PWM
- dir_l, dir_r  out  1  1 = forward, 0 = reverse
- state_o  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk_50. rst_n is synchronous and active-low; it is sampled on the rising edge of clk_50.
- Reset values:
  - state = IDLE.
  - Filtered word = 000; filter counter = 0.
  - node_count = 0.
  - pwm_l = pwm_r = 0; dir_l = dir_r = 1.
  - cmd_ready = 0; node_pulse = 0.
  - The PWM counter is cleared.
- Filter:
  - The raw word is registered once.
  - If it equals the previous raw word, the counter increments, saturating at FILT_CYCLES-1. Otherwise the counter clears.
  - When the counter reaches FILT_CYCLES-1, the filtered word loads the raw word.
  - Latency from a stable input to the filtered output is FILT_CYCLES+1 cycles.
- PWM:
  - A free-running counter runs from 0 to PWM_PERIOD-1.
  - pwm_x = (cnt < duty_x), registered.
  - Duty 0 gives a constant low output.
  - The duty value is applied at counter wrap only, so there are no glitches.
- States and transitions (F = filtered word, written r-c-l as bits 2-1-0):
  - IDLE: duty 0/0. Goes to FOLLOW when run_en = 1.
  - FOLLOW:
    - F = 010: duty FAST/FAST.
    - F = 011 or 001: CORR_L, duty left SLOW, right FAST.
    - F = 110 or 100: CORR_R, mirrored.
    - F = 111: goes to NODE.
    - F = 000 held for LOST_TIMEOUT: goes to LOST.
    - F = 101: treated as 010.
  - CORR_L / CORR_R: return to FOLLOW when F = 010. NODE and LOST checks are identical to FOLLOW.
  - NODE:
    - On entry: duty 0/0, node_pulse for 1 cycle, node_count += 1 (wraps 255 to 0), cmd_ready = 1.
    - On cmd_valid & cmd_ready:
      - dir 0: goes to EXIT.
      - dir 1 or 2: goes to TURN.
      - dir 3: goes to IDLE.
  - EXIT: FAST/FAST until F != 111, then FOLLOW. This prevents double-counting the node.
  - TURN:
    - Spin in place. Left turn: dir_l = 0, dir_r = 1, both FAST. Right turn is the mirror.
    - Returns to FOLLOW when the turn timer ≥ TURN_MIN and F[1] = 1.
  - LOST: behaviour depends on the optional feature.
- Precedence:
  - run_en = 0 in any state forces IDLE the next cycle, cancels any pending command, and does not change node_count.
  - A simultaneous node_pulse and run_en fall still counts the node.
- Timers:
  - The lost and turn timers clear on every state change.
  - They saturate rather than wrap.

Optional Feature:
- Macro: LF_LOST_RECOVERY_EN.
- Defined:
  - LOST spins toward the last non-zero side. If the last word had bit0 set, spin left; otherwise spin right.
  - Both wheels run at SLOW.
  - LOST goes to FOLLOW when F != 000.
- Undefined:
  - LOST holds duty 0/0.
  - Exit from LOST is only via run_en = 0 (to IDLE).

Decomposition:
- Shared package lf_pkg holds:
  - The state enum (IDLE=0, FOLLOW, CORR_L, CORR_R, NODE, EXIT, TURN, LOST).
  - The cmd_dir constants.
  - The sensor bit-index constants.
- One sub-module, motor_pwm: PWM counter plus two comparators with wrap-synchronous duty load, instantiated once for both wheels.

Test Plan (bench parameters: FILT_CYCLES=4, PWM_PERIOD=10, DUTY_FAST=8, DUTY_SLOW=3, TURN_MIN=20, LOST_TIMEOUT=30):
- Reset, then run_en = 1 with line_ls = 010 → filtered word updates after 5 cycles; state FOLLOW; pwm_l and pwm_r each high 8 of 10 cycles.
- line_ls toggles 010/011 every 2 cycles → filtered word never changes; state stays FOLLOW.
- line_ls = 111 held → one node_pulse, node_count = 1, cmd_ready = 1. Then cmd_dir = 1 with valid → TURN with dir_l = 0. Driving 010 at cycle 10 does not exit; exit occurs at cycle ≥ 20.
- line_ls = 000 for 30+ filtered cycles → LOST. With the macro defined, last side right gives a right spin at duty 3; without it, duty is 0.
- 256 node/straight sequences → node_count wraps to 0; every pass through EXIT produces exactly one count.
- rst_n = 0 asserted mid-TURN → next edge: IDLE, node_count = 0, duty 0, dir_l = dir_r = 1.
